// File: rtl/bsg_nonsynth_dramsim3.sv
// bsg_nonsynth_dramsim3: behavioral multi-channel DRAM with fixed-latency in-order completions
module bsg_nonsynth_dramsim3 #(
    parameter int channel_addr_width_p = 32,
    parameter int data_width_p = 256,
    parameter int num_channels_p = 8,
    parameter int num_columns_p = 64,
    parameter int num_rows_p = 32768,
    parameter int num_ba_p = 4,
    parameter int num_bg_p = 4,
    parameter int num_ranks_p = 1,
    parameter longint size_in_bits_p = 64'd1 << 33,
    parameter int address_mapping_p = 0,
    parameter config_p = "",
    parameter bit masked_p = 0,
    parameter bit debug_p = 0,
    parameter bit init_mem_p = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic [num_channels_p-1:0] v_i,
    input  logic [num_channels_p-1:0] write_not_read_i,
    input  logic [num_channels_p-1:0][channel_addr_width_p-1:0] ch_addr_i,
    output logic [num_channels_p-1:0] yumi_o,
    input  logic [num_channels_p-1:0] data_v_i,
    input  logic [num_channels_p-1:0][data_width_p-1:0] data_i,
    input  logic [num_channels_p-1:0][data_width_p/8-1:0] mask_i,
    output logic [num_channels_p-1:0] data_yumi_o,
    output logic [num_channels_p-1:0] data_v_o,
    output logic [num_channels_p-1:0][data_width_p-1:0] data_o,
    output logic [num_channels_p-1:0][channel_addr_width_p-1:0] read_done_ch_addr_o,
    output logic [num_channels_p-1:0] write_done_o,
    output logic [num_channels_p-1:0][channel_addr_width_p-1:0] write_done_ch_addr_o
);
    localparam int bytes_lp = data_width_p / 8;
    localparam int off_lp = $clog2(bytes_lp);
    localparam longint words_lp = size_in_bits_p / num_channels_p / data_width_p;
    localparam int idx_w_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam int latency_lp = 20;
    localparam int depth_lp = 16;

    logic [63:0] cycle_r;

    // free-running cycle count that timestamps every accepted request
    always_ff @(posedge clk_i) begin
        cycle_r <= reset_i ? '0 : cycle_r + 64'd1;
    end

    for (genvar c = 0; c < num_channels_p; c++) begin : ch
        logic [data_width_p-1:0] mem [0:words_lp-1];
        logic q_wr [depth_lp];
        logic [channel_addr_width_p-1:0] q_addr [depth_lp];
        logic [data_width_p-1:0] q_data [depth_lp];
        logic [63:0] q_time [depth_lp];
        logic [3:0] wp_r, rp_r;
        logic [4:0] cnt_r;
        logic [idx_w_lp-1:0] idx;
        logic acc, ret, is_wr;

        assign idx = idx_w_lp'((64'(ch_addr_i[c]) >> off_lp) % 64'(words_lp));
        assign is_wr = write_not_read_i[c];
        assign acc = ~reset_i & v_i[c] & (cnt_r != 5'(depth_lp)) & (~is_wr | data_v_i[c]);
        assign ret = ~reset_i & (cnt_r != '0) & (cycle_r >= q_time[rp_r]);
        assign yumi_o[c] = acc;
        assign data_yumi_o[c] = acc & is_wr;
        assign data_v_o[c] = ret & ~q_wr[rp_r];
        assign write_done_o[c] = ret & q_wr[rp_r];
        assign data_o[c] = data_v_o[c] ? q_data[rp_r] : '0;
        assign read_done_ch_addr_o[c] = data_v_o[c] ? q_addr[rp_r] : '0;
        assign write_done_ch_addr_o[c] = write_done_o[c] ? q_addr[rp_r] : '0;

        // in-order outstanding queue: push on accept, pop the head once its latency has elapsed
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                wp_r <= '0;
                rp_r <= '0;
                cnt_r <= '0;
            end else begin
                if (acc) begin
                    q_wr[wp_r] <= is_wr;
                    q_addr[wp_r] <= ch_addr_i[c];
                    q_data[wp_r] <= mem[idx];
                    q_time[wp_r] <= cycle_r + 64'(latency_lp);
                    wp_r <= wp_r + 4'd1;
                end
                if (ret)
                    rp_r <= rp_r + 4'd1;
                cnt_r <= cnt_r + 5'(acc) - 5'(ret);
            end
        end

        // backing store: written at the accepting edge, re-zeroed by reset when zero-init is enabled
        always_ff @(posedge clk_i) begin
            if (reset_i && init_mem_p) begin
                for (int w = 0; w < int'(words_lp); w++)
                    mem[w] <= '0;
            end else if (acc && is_wr) begin
                for (int b = 0; b < bytes_lp; b++)
                    if (!masked_p || mask_i[c][b])
                        mem[idx][b*8 +: 8] <= data_i[c][b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_bsg_nonsynth_dramsim3.sv
// tb_bsg_nonsynth_dramsim3: directed vector bench for the behavioral DRAM model
module tb_bsg_nonsynth_dramsim3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int NC = 2;
    localparam longint SZ = 64'd2 * 64'd1024 * 64'd64;

    logic clk = 0;
    logic reset_i = 1;
    logic [NC-1:0] v_i, write_not_read_i, data_v_i, yumi_o, data_yumi_o, data_v_o, write_done_o;
    logic [NC-1:0][AW-1:0] ch_addr_i, read_done_ch_addr_o, write_done_ch_addr_o;
    logic [NC-1:0][DW-1:0] data_i, data_o;
    logic [NC-1:0][DW/8-1:0] mask_i;

    bsg_nonsynth_dramsim3 #(
        .channel_addr_width_p(AW), .data_width_p(DW), .num_channels_p(NC),
        .size_in_bits_p(SZ), .masked_p(1'b0), .debug_p(1'b0), .init_mem_p(1'b1)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .write_not_read_i(write_not_read_i),
        .ch_addr_i(ch_addr_i), .yumi_o(yumi_o), .data_v_i(data_v_i), .data_i(data_i),
        .mask_i(mask_i), .data_yumi_o(data_yumi_o), .data_v_o(data_v_o), .data_o(data_o),
        .read_done_ch_addr_o(read_done_ch_addr_o), .write_done_o(write_done_o),
        .write_done_ch_addr_o(write_done_ch_addr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ch;
        bit wr;
        int cyc;
        logic [31:0] addr;
        logic [63:0] data;
    } ev_t;

    typedef struct {
        int ch;
        bit v;
        bit wnr;
        bit dv;
        logic [31:0] a;
        logic [63:0] d;
        bit ey;
        bit edy;
    } vec_t;

    ev_t got_q[$];
    ev_t exp_q[$];
    logic [63:0] model [longint];
    vec_t tbl [12];
    int vectors = 0;
    int fails = 0;

    // completion monitor plus the "outputs are zero while their valid is low" rule
    always @(negedge clk) begin
        if (!reset_i) begin
            for (int ch = 0; ch < NC; ch++) begin
                if (data_v_o[ch])
                    got_q.push_back('{ch, 1'b0, cyc, read_done_ch_addr_o[ch], data_o[ch]});
                if (write_done_o[ch])
                    got_q.push_back('{ch, 1'b1, cyc, write_done_ch_addr_o[ch], data_o[ch]});
                vectors++;
                if ((data_v_o[ch] && write_done_o[ch]) ||
                    (!data_v_o[ch] && (data_o[ch] !== '0 || read_done_ch_addr_o[ch] !== '0)) ||
                    (!write_done_o[ch] && write_done_ch_addr_o[ch] !== '0)) begin
                    fails++;
                    $display("FAIL idle_zero ch%0d cyc%0d: dv=%b wd=%b data=%h raddr=%h waddr=%h required zero/exclusive",
                             ch, cyc, data_v_o[ch], write_done_o[ch], data_o[ch],
                             read_done_ch_addr_o[ch], write_done_ch_addr_o[ch]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        v_i = '0;
        write_not_read_i = '0;
        data_v_i = '0;
        ch_addr_i = '0;
        data_i = '0;
        mask_i = '1;
    endtask

    task automatic put(input int ch, input bit v, input bit wnr, input bit dv,
                       input logic [31:0] a, input logic [63:0] d);
        idle();
        v_i[ch] = v;
        write_not_read_i[ch] = wnr;
        data_v_i[ch] = dv;
        ch_addr_i[ch] = a;
        data_i[ch] = d;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_acc(input int ch, input bit wr, input logic [31:0] a,
                           input logic [63:0] d, input int at);
        longint key;
        key = longint'(ch) * 64'd1048576 + longint'((a >> 3) % 1024);
        if (wr) begin
            model[key] = d;
            exp_q.push_back('{ch, 1'b1, at + 20, a, 64'd0});
        end else begin
            exp_q.push_back('{ch, 1'b0, at + 20, a, model.exists(key) ? model[key] : 64'd0});
        end
    endtask

    task automatic cmp_events(input string tag);
        ev_t e, g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                fails++;
                $display("FAIL %s missing: got nothing expected ch%0d wr%0d cyc%0d addr %h data %h",
                         tag, e.ch, e.wr, e.cyc, e.addr, e.data);
            end else begin
                g = got_q.pop_front();
                if (g.ch != e.ch || g.wr != e.wr || g.cyc != e.cyc || g.addr !== e.addr || g.data !== e.data) begin
                    fails++;
                    $display("FAIL %s event: got ch%0d wr%0d cyc%0d addr %h data %h expected ch%0d wr%0d cyc%0d addr %h data %h",
                             tag, g.ch, g.wr, g.cyc, g.addr, g.data, e.ch, e.wr, e.cyc, e.addr, e.data);
                end
            end
        end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            vectors++;
            fails++;
            $display("FAIL %s extra: got ch%0d wr%0d cyc%0d addr %h expected no completion",
                     tag, g.ch, g.wr, g.cyc, g.addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int start, acc;
        int acc_cyc [17];
        tbl[0]  = '{0, 1'b0, 1'b0, 1'b0, 32'h0,    64'h0,        1'b0, 1'b0};
        tbl[1]  = '{0, 1'b1, 1'b1, 1'b0, 32'h40,   64'hABCD,     1'b0, 1'b0};
        tbl[2]  = '{0, 1'b1, 1'b1, 1'b1, 32'h40,   64'hABCD,     1'b1, 1'b1};
        tbl[3]  = '{0, 1'b0, 1'b1, 1'b1, 32'h40,   64'h5555,     1'b0, 1'b0};
        tbl[4]  = '{0, 1'b1, 1'b0, 1'b0, 32'h40,   64'h0,        1'b1, 1'b0};
        tbl[5]  = '{0, 1'b1, 1'b0, 1'b0, 32'h1000, 64'h0,        1'b1, 1'b0};
        tbl[6]  = '{0, 1'b1, 1'b1, 1'b1, 32'h20,   64'h1111,     1'b1, 1'b1};
        tbl[7]  = '{1, 1'b1, 1'b1, 1'b1, 32'h20,   64'h2222,     1'b1, 1'b1};
        tbl[8]  = '{1, 1'b1, 1'b0, 1'b0, 32'h20,   64'h0,        1'b1, 1'b0};
        tbl[9]  = '{0, 1'b1, 1'b0, 1'b0, 32'h20,   64'h0,        1'b1, 1'b0};
        tbl[10] = '{1, 1'b1, 1'b0, 1'b0, 32'h40,   64'h0,        1'b1, 1'b0};
        tbl[11] = '{0, 1'b0, 1'b0, 1'b1, 32'h40,   64'h7777,     1'b0, 1'b0};

        idle();
        v_i = '1;
        data_v_i = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_yumi", 64'(yumi_o), 64'd0);
        chk("reset_data_yumi", 64'(data_yumi_o), 64'd0);
        chk("reset_data_v", 64'(data_v_o), 64'd0);
        chk("reset_write_done", 64'(write_done_o), 64'd0);
        @(posedge clk);
        #1;
        reset_i = 0;
        idle();
        next();

        foreach (tbl[i]) begin
            put(tbl[i].ch, tbl[i].v, tbl[i].wnr, tbl[i].dv, tbl[i].a, tbl[i].d);
            @(negedge clk);
            chk($sformatf("vec%0d_yumi", i), 64'(yumi_o[tbl[i].ch]), 64'(tbl[i].ey));
            chk($sformatf("vec%0d_data_yumi", i), 64'(data_yumi_o[tbl[i].ch]), 64'(tbl[i].edy));
            if (tbl[i].ey)
                exp_acc(tbl[i].ch, tbl[i].wnr, tbl[i].a, tbl[i].d, cyc);
            next();
        end
        idle();
        repeat (25) next();
        cmp_events("table");

        start = cyc;
        acc = 0;
        foreach (acc_cyc[k]) acc_cyc[k] = -1;
        for (int t = 0; t < 40 && acc < 17; t++) begin
            put(0, 1'b1, 1'b0, 1'b0, 32'h40 + 32'(8 * acc), 64'h0);
            @(negedge clk);
            if (yumi_o[0]) begin
                acc_cyc[acc] = cyc;
                acc++;
            end
            next();
        end
        idle();
        chk("burst_accepted", 64'(acc), 64'd17);
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("burst_acc_cyc%0d", k), 64'(acc_cyc[k] - start), 64'(k < 16 ? k : 21));
            exp_acc(0, 1'b0, 32'h40 + 32'(8 * k), 64'h0, start + (k < 16 ? k : 21));
        end
        repeat (25) next();
        cmp_events("burst");

        for (int k = 0; k < 5; k++) begin
            put(0, 1'b1, 1'b0, 1'b0, 32'h40, 64'h0);
            next();
        end
        idle();
        repeat (3) next();
        reset_i = 1;
        put(0, 1'b1, 1'b0, 1'b0, 32'h40, 64'h0);
        @(negedge clk);
        chk("midreset_yumi", 64'(yumi_o), 64'd0);
        next();
        reset_i = 0;
        idle();
        model.delete();
        got_q.delete();
        repeat (30) next();
        put(0, 1'b1, 1'b0, 1'b0, 32'h40, 64'h0);
        @(negedge clk);
        chk("postreset_yumi", 64'(yumi_o[0]), 64'd1);
        exp_acc(0, 1'b0, 32'h40, 64'h0, cyc);
        next();
        idle();
        repeat (22) next();
        cmp_events("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
